bus_select_reg: RTL

//  Parametrised N-source datapath bus selector with a registered output. It replaces the

---
 rtl/bus_select_reg_pkg.sv | 25 ++
 rtl/bus_prio_enc.sv | 28 ++
 rtl/bus_select_reg.sv | 80 ++++++++
 3 files changed

// File: rtl/bus_select_reg_pkg.sv
// Shared bus constants: source indices used by the datapath and the control unit.
// Also holds the default bus geometry and a helper for the source-index width.
package bus_select_reg_pkg;

   localparam int BUS_WIDTH = 16;
   localparam int BUS_NSRC  = 11;

   localparam int SRC_DIN  = 0;
   localparam int SRC_R0   = 1;
   localparam int SRC_R1   = 2;
   localparam int SRC_R2   = 3;
   localparam int SRC_R3   = 4;
   localparam int SRC_R4   = 5;
   localparam int SRC_R5   = 6;
   localparam int SRC_R6   = 7;
   localparam int SRC_R7   = 8;
   localparam int SRC_G    = 9;
   localparam int SRC_DOUT = 10;

   // Index width for n sources, never less than one bit.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bus_prio_enc.sv
// Combinational lowest-index priority encoder over the source drive requests.
// Also reports whether any request is set and whether two or more are set.
module bus_prio_enc
   import bus_select_reg_pkg::*;
#(
   parameter int NSRC = BUS_NSRC,
   parameter int ID_W = id_width(NSRC)
) (
   input  logic [NSRC-1:0] src_en,
   output logic [ID_W-1:0] winner,
   output logic            any_set,
   output logic            multi_set
);

   always_comb begin
      // NOTE: combinational logic uses blocking '=' and assigns a default first,
      // so every path drives winner and no latch is inferred.
      winner = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (src_en[i]) winner = ID_W'(i);
      end
   end

   assign any_set   = |src_en;
   // Clearing the lowest set bit leaves something only if two or more were set.
   assign multi_set = |(src_en & (src_en - NSRC'(1)));

endmodule

// File: rtl/bus_select_reg.sv
// Registered N-source bus selector with hold, valid flag and contention detection.
// Optional saturating contention counter enabled by defining BUS_CONFLICT_CNT_EN.
module bus_select_reg
   import bus_select_reg_pkg::*;
#(
   parameter int WIDTH = BUS_WIDTH,
   parameter int NSRC  = BUS_NSRC,
   parameter int CNT_W = 8,
   parameter int ID_W  = id_width(NSRC)
) (
   input  logic                  Clock,
   input  logic                  Resetn,
   input  logic [NSRC*WIDTH-1:0] src_data,
   input  logic [NSRC-1:0]       src_en,
   input  logic                  err_clr,
   output logic [WIDTH-1:0]      bus_q,
   output logic                  bus_valid,
   output logic [ID_W-1:0]       src_id,
   output logic                  conflict,
   output logic                  conflict_sticky,
   output logic [CNT_W-1:0]      conflict_cnt
);

   logic [ID_W-1:0]  winner;
   logic             any_set;
   logic             multi_set;
   logic [WIDTH-1:0] sel_data;

   bus_prio_enc #(.NSRC(NSRC), .ID_W(ID_W)) u_prio_enc (
      .src_en    (src_en),
      .winner    (winner),
      .any_set   (any_set),
      .multi_set (multi_set)
   );

   // Constant-index slices keep the mux width-exact for any WIDTH/NSRC.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (winner == ID_W'(i)) sel_data = src_data[i*WIDTH +: WIDTH];
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      // NOTE: sequential state uses non-blocking '<=' so every register
      // samples the pre-edge values regardless of statement order.
      if (!Resetn) begin
         bus_q           <= '0;
         src_id          <= '0;
         bus_valid       <= 1'b0;
         conflict        <= 1'b0;
         conflict_sticky <= 1'b0;
      end else begin
         if (any_set) begin
            bus_q  <= sel_data;
            src_id <= winner;
         end
         bus_valid       <= any_set;
         conflict        <= multi_set;
         conflict_sticky <= multi_set | (conflict_sticky & ~err_clr);
      end
   end

`ifdef BUS_CONFLICT_CNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         conflict_cnt <= '0;
      end else if (err_clr) begin
         conflict_cnt <= multi_set ? CNT_W'(1) : '0;
      end else if (multi_set && conflict_cnt != CNT_MAX) begin
         conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
   end
`else
   assign conflict_cnt = '0;
`endif

endmodule
